// File: rtl/data_mem32_if.sv
// Request/response bundle between the MEM stage and data_mem32.
// The master drives requests; the slave returns load data and error pulses.
interface data_mem32_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              rd_valid;
  logic              misalign;
  logic              range_err;

  modport master (
    output mem_read, mem_write, size, unsigned_ld, address, data_in,
    input  data_out, rd_valid, misalign, range_err
  );

  modport slave (
    input  mem_read, mem_write, size, unsigned_ld, address, data_in,
    output data_out, rd_valid, misalign, range_err
  );
endinterface

// File: rtl/data_mem32.sv
// Byte-addressed 32-bit data memory with byte/half/word stores, sign/zero-extended
// sub-word loads, a pipelined read path of READ_LAT cycles and registered error pulses.
module data_mem32 #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned READ_LAT   = 1
) (
  input logic         clk,
  input logic         rst_n,
  data_mem32_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $error("data_mem32: READ_LAT must be in 1..4");
  end

  typedef struct packed {
    logic        v;
    logic [31:0] word;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        uns;
  } rd_t;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  oor;
  logic                  illegal;
  logic                  mis;
  logic                  flag_mis;
  logic                  flag_rng;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [3:0]            be;
  logic [31:0]           wdata;
  rd_t                   req_s;
  rd_t                   tail;

  assign idx  = bus.address[DEPTH_LOG2+1:2];
  assign lane = bus.address[1:0];

  if (ADDR_W > DEPTH_LOG2 + 2) begin : g_hi
    assign oor = |bus.address[ADDR_W-1:DEPTH_LOG2+2];
  end else begin : g_no_hi
    assign oor = 1'b0;
  end

  always_comb begin
    illegal  = (bus.mem_read && bus.mem_write) || (bus.size == 2'b11);
    mis      = ((bus.size == 2'b01) && lane[0]) ||
               ((bus.size == 2'b10) && (lane != 2'b00));
    flag_mis = (bus.mem_read || bus.mem_write) && !illegal && mis;
    flag_rng = (bus.mem_read || bus.mem_write) && (illegal || oor);
    wr_ok    = bus.mem_write && !illegal && !mis && !oor;
    rd_ok    = bus.mem_read && !illegal;

    // Store data is replicated across lanes so each enabled lane picks its own byte
    be    = '0;
    wdata = bus.data_in;
    case (bus.size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.data_in[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.data_in[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      if (be[0]) mem[idx][7:0]   <= wdata[7:0];
      if (be[1]) mem[idx][15:8]  <= wdata[15:8];
      if (be[2]) mem[idx][23:16] <= wdata[23:16];
      if (be[3]) mem[idx][31:24] <= wdata[31:24];
    end
  end

  // Faulting reads still travel the pipe so rd_valid keeps its fixed latency
  always_comb begin
    req_s      = '0;
    req_s.v    = rd_ok;
    req_s.word = (mis || oor) ? '0 : mem[idx];
    req_s.lane = lane;
    req_s.size = bus.size;
    req_s.uns  = bus.unsigned_ld;
  end

  if (READ_LAT == 1) begin : g_lat1
    assign tail = req_s;
  end else begin : g_pipe
    rd_t [READ_LAT-2:0] pipe;

    if (READ_LAT == 2) begin : g_one
      always_ff @(posedge clk) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= req_s;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[READ_LAT-3:0], req_s};
      end
    end

    assign tail = pipe[READ_LAT-2];
  end

  function automatic logic [31:0] load_ext(input rd_t s);
    logic [31:0] sh;
    sh = s.word >> {s.lane, 3'b000};
    case (s.size)
      2'b00:   load_ext = s.uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_ext = s.uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_ext = s.word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.data_out  <= '0;
      bus.rd_valid  <= 1'b0;
      bus.misalign  <= 1'b0;
      bus.range_err <= 1'b0;
    end else begin
      bus.rd_valid  <= tail.v;
      if (tail.v) bus.data_out <= load_ext(tail);
      bus.misalign  <= flag_mis;
      bus.range_err <= flag_rng;
    end
  end

endmodule
